pipeline_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 16 +
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the FSM state encoding, the default memory timeout and REG_ZERO.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int WAIT_CNT_W      = 8;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
// Ports: clk, reset, i_en (count this cycle), o_cnt (holds at all-ones).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;

  assign w_full = &r_cnt;
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_en && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flush, memory freeze/timeout.
// Inputs: ID/EX load info, IF/ID sources, Branch_taken, EX/MEM access, dmem_ready.
// Outputs: PC_Write, IF_ID_Write, IF_ID_Flush, ID_Flush_lwstall, Pipe_Hold,
// mem_error, state. Define HAZARD_STATS_EN to add saturating stall counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRt,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRt,
  input  logic             Branch_taken,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_Flush_lwstall,
  output logic             Pipe_Hold,
  output logic             mem_error,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]       state
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
    WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_cnt_nxt;
  logic                  r_mem_error;
  logic                  w_err_nxt;

  logic w_mem_access;
  logic w_freeze_req;
  logic w_rs_match;
  logic w_rt_match;
  logic w_lw_hazard;
  logic w_hold;

  assign w_mem_access = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign w_freeze_req = w_mem_access & ~dmem_ready;

  assign w_rs_match  = (ID_EX_RegisterRt == IF_ID_RegisterRs);
  assign w_rt_match  = IF_ID_UsesRt &
                       (ID_EX_RegisterRt == IF_ID_RegisterRt);
  assign w_lw_hazard = ID_EX_MemRead &
                       (ID_EX_RegisterRt != REG_ZERO) &
                       (w_rs_match | w_rt_match);

  assign w_hold = (r_state == ERR) | w_freeze_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_error <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_mem_error;
    unique case (r_state)
      RUN: begin
        if (w_freeze_req) begin
          w_state_nxt = MEM_WAIT;
          w_cnt_nxt   = WAIT_CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST_WAIT) begin
          w_state_nxt = ERR;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ERR: begin
        w_state_nxt = ERR;
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Freeze outranks everything: a pending hazard or branch is held in
  // the frozen registers and re-evaluated once the freeze lifts.
  always_comb begin
    PC_Write         = 1'b1;
    IF_ID_Write      = 1'b1;
    IF_ID_Flush      = 1'b0;
    ID_Flush_lwstall = 1'b0;
    Pipe_Hold        = 1'b0;
    if (w_hold) begin
      Pipe_Hold   = 1'b1;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (w_lw_hazard) begin
      // Branch operands are stale here; branch resolves next cycle.
      PC_Write         = 1'b0;
      IF_ID_Write      = 1'b0;
      ID_Flush_lwstall = 1'b1;
    end else if (Branch_taken) begin
      IF_ID_Flush = 1'b1;
      PC_Write    = 1'b1;
    end
  end

  assign mem_error = r_mem_error;
  assign state     = r_state;

`ifdef HAZARD_STATS_EN
  sat_counter #(.CNT_W(CNT_W)) u_lw_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (ID_Flush_lwstall),
    .o_cnt (lw_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (Pipe_Hold),
    .o_cnt (mem_wait_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (IF_ID_Flush),
    .o_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Expected output vectors are queued at drive time and popped at sample time.
module tb_pipeline_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 3;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_Flush_lwstall,
  //  Pipe_Hold, mem_error, state[1:0]}
  localparam logic [7:0] E_RUN   = 8'b1100_0000;
  localparam logic [7:0] E_RUNW  = 8'b1100_0001;
  localparam logic [7:0] E_STALL = 8'b0001_0000;
  localparam logic [7:0] E_STW   = 8'b0001_0001;
  localparam logic [7:0] E_BR    = 8'b1110_0000;
  localparam logic [7:0] E_HOLD0 = 8'b0000_1000;
  localparam logic [7:0] E_HOLDW = 8'b0000_1001;
  localparam logic [7:0] E_ERR   = 8'b0000_1110;

  logic       clk = 1'b0;
  logic       reset;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_RegisterRt;
  logic [4:0] IF_ID_RegisterRs;
  logic [4:0] IF_ID_RegisterRt;
  logic       IF_ID_UsesRt;
  logic       Branch_taken;
  logic       EX_MEM_MemRead;
  logic       EX_MEM_MemWrite;
  logic       dmem_ready;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_Flush_lwstall;
  logic       Pipe_Hold;
  logic       mem_error;
  logic [1:0] state;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] lw_stall_cnt;
  logic [CW-1:0] mem_wait_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_RegisterRt (ID_EX_RegisterRt),
    .IF_ID_RegisterRs (IF_ID_RegisterRs),
    .IF_ID_RegisterRt (IF_ID_RegisterRt),
    .IF_ID_UsesRt     (IF_ID_UsesRt),
    .Branch_taken     (Branch_taken),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .dmem_ready       (dmem_ready),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_Flush_lwstall (ID_Flush_lwstall),
    .Pipe_Hold        (Pipe_Hold),
    .mem_error        (mem_error),
`ifdef HAZARD_STATS_EN
    .lw_stall_cnt     (lw_stall_cnt),
    .mem_wait_cnt     (mem_wait_cnt),
    .flush_cnt        (flush_cnt),
`endif
    .state            (state)
  );

  function automatic logic [7:0] obs();
    return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_Flush_lwstall,
            Pipe_Hold, mem_error, state};
  endfunction

  task automatic drive(input logic lr, input logic [4:0] xrt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic br,
                       input logic mr, input logic mw,
                       input logic rdy);
    ID_EX_MemRead    = lr;
    ID_EX_RegisterRt = xrt;
    IF_ID_RegisterRs = rs;
    IF_ID_RegisterRt = rt;
    IF_ID_UsesRt     = ur;
    Branch_taken     = br;
    EX_MEM_MemRead   = mr;
    EX_MEM_MemWrite  = mw;
    dmem_ready       = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One clock: drive at negedge, check mid-low phase, cross the posedge.
  task automatic cyc(input logic lr, input logic [4:0] xrt,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic ur, input logic br,
                     input logic mr, input logic mw,
                     input logic rdy, input logic [7:0] e,
                     input string nm);
    logic [7:0] exp_v;
    string      n;
    drive(lr, xrt, rs, rt, ur, br, mr, mw, rdy);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #2;
    exp_v = exp_q.pop_front();
    n     = name_q.pop_front();
    n_tests++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", n, obs(), exp_v);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic [7:0] exp_v;
    @(negedge clk);
    idle();
    reset = 1'b1;
    exp_q.push_back(E_RUN);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset: got %b expected %b", obs(), exp_v);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    do_reset();
    cyc(0,0,0,0,0,0,0,0,1, E_RUN, "reset_idle");
  endtask

  task automatic test_load_use();
    cyc(1,5,5,0,0,0,0,0,1, E_STALL, "lu_stall");
    cyc(0,5,5,0,0,0,0,0,1, E_RUN,   "lu_after");
    cyc(1,0,0,0,1,0,0,0,1, E_RUN,   "lu_rt_zero");
    cyc(1,5,6,9,1,0,0,0,1, E_RUN,   "lu_no_match");
  endtask

  task automatic test_rt_only();
    cyc(1,7,1,7,0,0,0,0,1, E_RUN,   "rt_unused");
    cyc(1,7,1,7,1,0,0,0,1, E_STALL, "rt_used");
    cyc(0,7,1,7,1,0,0,0,1, E_RUN,   "rt_after");
  endtask

  task automatic test_branch();
    cyc(0,0,3,4,1,1,0,0,1, E_BR,    "br_flush");
    cyc(1,5,5,0,0,1,0,0,1, E_STALL, "br_vs_lw");
    cyc(0,5,5,0,0,1,0,0,1, E_BR,    "br_retry");
    cyc(0,0,0,0,0,0,0,0,1, E_RUN,   "br_done");
  endtask

  task automatic test_mem_wait();
    cyc(1,5,5,0,0,0,1,0,0, E_HOLD0, "mw_hold1");
    cyc(1,5,5,0,0,0,1,0,0, E_HOLDW, "mw_hold2");
    cyc(1,5,5,0,0,0,1,0,0, E_HOLDW, "mw_hold3");
    cyc(1,5,5,0,0,0,1,0,1, E_STW,   "mw_release_lw");
    cyc(0,5,5,0,0,0,0,0,1, E_RUN,   "mw_run");
    cyc(0,0,0,0,0,0,0,1,1, E_RUN,   "mw_ready_now");
    cyc(0,0,0,0,0,0,0,0,1, E_RUN,   "mw_no_state");
  endtask

  task automatic test_timeout();
    logic [7:0] exp_v;
    cyc(0,0,0,0,0,0,1,0,0, E_HOLD0, "to_c0");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLDW, "to_c1");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLDW, "to_c2");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLDW, "to_c3");
    cyc(0,0,0,0,0,0,1,0,0, E_ERR,   "to_err");
    cyc(1,5,5,0,0,1,0,0,1, E_ERR,   "to_sticky");
    idle();
    #3;
    reset = 1'b1;
    exp_q.push_back(E_RUN);
    #1;
    exp_v = exp_q.pop_front();
    n_tests++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL to_async_reset: got %b expected %b", obs(), exp_v);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait counter must restart after reset/release, so 3+3 waits never err.
  task automatic test_back_to_back();
    cyc(0,0,0,0,0,0,0,1,0, E_HOLD0, "bb_a0");
    cyc(0,0,0,0,0,0,0,1,0, E_HOLDW, "bb_a1");
    cyc(0,0,0,0,0,0,0,1,0, E_HOLDW, "bb_a2");
    cyc(0,0,0,0,0,0,0,1,1, E_RUNW,  "bb_a_rel");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLD0, "bb_b0");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLDW, "bb_b1");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLDW, "bb_b2");
    cyc(0,0,0,0,0,0,1,0,1, E_RUNW,  "bb_b_rel");
    cyc(0,0,0,0,0,0,0,0,1, E_RUN,   "bb_idle");
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1,5,5,0,0,0,0,0,1, E_STALL, "st_lw");
      cyc(0,0,0,0,0,0,0,0,1, E_RUN,   "st_gap");
    end
    cyc(0,0,0,0,0,0,1,0,0, E_HOLD0, "st_w0");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLDW, "st_w1");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLDW, "st_w2");
    cyc(0,0,0,0,0,0,1,0,1, E_RUNW,  "st_w_rel");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLD0, "st_w3");
    cyc(0,0,0,0,0,0,1,0,0, E_HOLDW, "st_w4");
    cyc(0,0,0,0,0,0,1,0,1, E_RUNW,  "st_w_rel2");
    cyc(0,0,0,0,0,1,0,0,1, E_BR,    "st_br0");
    cyc(0,0,0,0,0,1,0,0,1, E_BR,    "st_br1");
    idle();
    #2;
    n_tests++;
    if (lw_stall_cnt !== CW'(3)) begin
      n_fail++;
      $display("FAIL st_lw_cnt: got %0d expected 3", lw_stall_cnt);
    end
    n_tests++;
    if (mem_wait_cnt !== CW'(5)) begin
      n_fail++;
      $display("FAIL st_wait_cnt: got %0d expected 5", mem_wait_cnt);
    end
    n_tests++;
    if (flush_cnt !== CW'(2)) begin
      n_fail++;
      $display("FAIL st_flush_cnt: got %0d expected 2", flush_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,0,0,0,1,0,0, (i == 0) ? E_HOLD0 : E_HOLDW, "st_sat");
    end
    cyc(0,0,0,0,0,0,0,0,1, E_RUNW, "st_sat_rel");
    #2;
    n_tests++;
    if (mem_wait_cnt !== '1) begin
      n_fail++;
      $display("FAIL st_saturate: got %0d expected %0d",
               mem_wait_cnt, (1 << CW) - 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_rt_only();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
